// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Output buffer depth; the credit logic relies on this being 2.
  localparam int FIFO_DEPTH = 2;
  // Width of an occupancy count that can represent 0..FIFO_DEPTH.
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ram_stream_reader_skid_fifo2.sv
// Two-entry FIFO carrying {last, data} words between RAM read data and the
// output stream. Head is presented combinationally from storage registers, so
// it stays stable while the consumer stalls.
module skid_fifo2
  import ram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  // Qualify push/pop against occupancy and derive the next count.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != FULL) || do_pop);
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage, pointers and count; a push into a full FIFO that pops in the same
  // cycle writes the slot being vacated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ram_stream_reader.sv
// Sequential RAM read engine: issues one read per cycle subject to buffer
// credit and streams returned words out with a last-beat marker.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  ADDRESSES  = 256,
  localparam int AW         = $clog2(ADDRESSES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         ram_addr,
  output logic                  ram_write,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam logic [AW-1:0]  LAST_ADDR = AW'(ADDRESSES - 1);
  localparam logic [CNT_W:0] OCC_MAX   = (CNT_W + 1)'(FIFO_DEPTH);

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW:0]         remaining_q, remaining_d;
  logic                inflight_q, inflight_d;
  logic                inflight_last_q, inflight_last_d;

  logic [CNT_W-1:0]    fifo_count;
  logic [DATA_WIDTH:0] fifo_head;
  logic                fifo_push;
  logic                fifo_pop;
  logic [CNT_W:0]      occupancy;
  logic                credit;
  logic                issue;
  logic [AW-1:0]       next_addr;

  // Buffer handshakes, read credit and the wrapped next address.
  always_comb begin
    out_valid = (fifo_count != '0);
    fifo_pop  = out_valid && out_ready;
    // Data for a read issued last cycle is on ram_data_out now.
    fifo_push = inflight_q;
    occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    credit    = (occupancy < OCC_MAX) || ((occupancy == OCC_MAX) && fifo_pop);
    issue     = (state_q == READ) && (remaining_q != '0) && credit;
    // Explicit compare so non-power-of-two depths wrap correctly.
    next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  end

  // Next-state logic for the command FSM and its address/count registers.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == (AW + 1)'(1));
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = DONE;
          end else begin
            state_d     = READ;
            addr_d      = base_addr;
            remaining_d = length;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d      = next_addr;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (AW + 1)'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Finish once the final word has left through the stream.
        if (!inflight_q && ((fifo_count == '0) ||
                            ((fifo_count == CNT_W'(1)) && fifo_pop))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, address, count and in-flight registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  skid_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .push_data({inflight_last_q, ram_data_out}),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign ram_addr  = addr_q;
  assign ram_write = 1'b0;
  assign out_data  = fifo_head[DATA_WIDTH-1:0];
  assign out_last  = fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed testbench for ram_stream_reader: a 256-deep instance for most
// scenarios and a 200-deep instance for the non-power-of-two wrap.
module tb_ram_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 256-word instance
  logic       reset, start, busy, done, ram_write, out_valid, out_ready, out_last;
  logic [7:0] base_addr, ram_addr, ram_data_out, out_data;
  logic [8:0] length;
  // 200-word instance
  logic       start2, busy2, done2, ram_write2, out_valid2, out_ready2, out_last2;
  logic [7:0] base_addr2, ram_addr2, ram_data_out2, out_data2;
  logic [8:0] length2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem  [256];
  logic [7:0] mem2 [200];

  logic [8:0] beats[$];
  int         beat_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         ovf = 0;
  logic [8:0] beats2[$];
  int         done2_cnt = 0;

  ram_stream_reader #(.DATA_WIDTH(8), .ADDRESSES(256)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_write(ram_write),
    .ram_data_out(ram_data_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  ram_stream_reader #(.DATA_WIDTH(8), .ADDRESSES(200)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .base_addr(base_addr2), .length(length2),
    .busy(busy2), .done(done2), .ram_addr(ram_addr2), .ram_write(ram_write2),
    .ram_data_out(ram_data_out2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_last(out_last2)
  );

  // RAM models preloaded with address value; registered read.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    for (int i = 0; i < 200; i++) mem2[i] = 8'(i);
  end

  always @(posedge clk) begin
    cyc           <= cyc + 1;
    ram_data_out  <= mem[ram_addr];
    ram_data_out2 <= mem2[ram_addr2];
  end

  // Stream monitors: record each handshake, done pulses and buffer overflow.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      beats.push_back({out_last, out_data});
      beat_cyc.push_back(cyc);
      $display("beat cyc=%0d data=%02h last=%0b", cyc, out_data, out_last);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (dut.fifo_push && (dut.fifo_count == 2'd2) && !dut.fifo_pop) ovf++;
    if (out_valid2 && out_ready2) begin
      beats2.push_back({out_last2, out_data2});
      $display("beat2 cyc=%0d data=%02h last=%0b", cyc, out_data2, out_last2);
    end
    if (done2) done2_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic clear_mon();
    beats.delete();
    beat_cyc.delete();
    beats2.delete();
    done_cnt  = 0;
    done2_cnt = 0;
  endtask

  task automatic issue_cmd(input logic [7:0] b, input logic [8:0] n, output int e0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = n;
    @(posedge clk); #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk); #1;
      if (done_cnt != 0) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = 8'h00; length = 9'd0; out_ready = 1'b1;
    start2 = 1'b0; base_addr2 = 8'h00; length2 = 9'd0; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h expected 0", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %0b expected 0", out_last); end
    total++; if (ram_addr !== 8'h00) begin bad++; $display("FAIL reset_addr: got %0h expected 0", ram_addr); end
    total++; if (ram_write !== 1'b0) begin bad++; $display("FAIL reset_write: got %0b expected 0", ram_write); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int e0;
    clear_mon();
    issue_cmd(8'h10, 9'd4, e0);
    total++; if (ram_addr !== 8'h10) begin bad++; $display("FAIL basic_addr: got %0h expected 10", ram_addr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %0b expected 1", busy); end
    wait_done(30);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
    total++; if (done_cyc != e0 + 6) begin bad++; $display("FAIL basic_done_cyc: got %0d expected %0d", done_cyc, e0 + 6); end
    total++; if (beats.size() != 4) begin bad++; $display("FAIL basic_count: got %0d expected 4", beats.size()); end
    for (int k = 0; k < beats.size() && k < 4; k++) begin
      logic [8:0] exp_b;
      exp_b = {(k == 3), 8'h10 + 8'(k)};
      total++; if (beats[k] !== exp_b) begin bad++; $display("FAIL basic_beat%0d: got %0h expected %0h", k, beats[k], exp_b); end
      total++; if (beat_cyc[k] != e0 + 2 + k) begin bad++; $display("FAIL basic_cyc%0d: got %0d expected %0d", k, beat_cyc[k], e0 + 2 + k); end
    end
  endtask

  task automatic test_wrap();
    int e0;
    clear_mon();
    issue_cmd(8'hFE, 9'd4, e0);
    wait_done(30);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL wrap_done: got %0d expected 1", done_cnt); end
    total++; if (beats.size() != 4) begin bad++; $display("FAIL wrap_count: got %0d expected 4", beats.size()); end
    for (int k = 0; k < beats.size() && k < 4; k++) begin
      logic [8:0] exp_b;
      exp_b = {(k == 3), 8'hFE + 8'(k)};
      total++; if (beats[k] !== exp_b) begin bad++; $display("FAIL wrap_beat%0d: got %0h expected %0h", k, beats[k], exp_b); end
    end
  endtask

  task automatic test_wrap200();
    int exp_a [3] = '{198, 199, 0};
    clear_mon();
    @(posedge clk); #1;
    start2 = 1'b1; base_addr2 = 8'd198; length2 = 9'd3;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (done2_cnt != 0) break;
    end
    total++; if (done2_cnt != 1) begin bad++; $display("FAIL wrap200_done: got %0d expected 1", done2_cnt); end
    total++; if (beats2.size() != 3) begin bad++; $display("FAIL wrap200_count: got %0d expected 3", beats2.size()); end
    for (int k = 0; k < beats2.size() && k < 3; k++) begin
      logic [8:0] exp_b;
      exp_b = {(k == 2), 8'(exp_a[k])};
      total++; if (beats2[k] !== exp_b) begin bad++; $display("FAIL wrap200_beat%0d: got %0h expected %0h", k, beats2[k], exp_b); end
    end
  endtask

  task automatic test_backpressure();
    int         e0;
    logic [31:0] rdy_pat;
    logic       hold;
    logic [8:0] held;
    clear_mon();
    ovf     = 0;
    rdy_pat = 32'hFFFF_D60D;  // includes a 5-cycle low run at bits 4..8
    hold    = 1'b0;
    held    = '0;
    issue_cmd(8'h20, 9'd8, e0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      out_ready = (i < 32) ? rdy_pat[i] : 1'b1;
      @(negedge clk);
      if (hold) begin
        total++;
        if (!out_valid || ({out_last, out_data} !== held)) begin
          bad++;
          $display("FAIL bp_stable: got valid=%0b word=%0h expected valid=1 word=%0h", out_valid, {out_last, out_data}, held);
        end
      end
      total++; if (ram_write !== 1'b0) begin bad++; $display("FAIL bp_write: got %0b expected 0", ram_write); end
      hold = out_valid && !out_ready;
      held = {out_last, out_data};
    end
    out_ready = 1'b1;
    #1;
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    total++; if (ovf != 0) begin bad++; $display("FAIL bp_overflow: got %0d expected 0", ovf); end
    total++; if (beats.size() != 8) begin bad++; $display("FAIL bp_count: got %0d expected 8", beats.size()); end
    for (int k = 0; k < beats.size() && k < 8; k++) begin
      logic [8:0] exp_b;
      exp_b = {(k == 7), 8'h20 + 8'(k)};
      total++; if (beats[k] !== exp_b) begin bad++; $display("FAIL bp_beat%0d: got %0h expected %0h", k, beats[k], exp_b); end
    end
  endtask

  task automatic test_len0();
    int e0;
    clear_mon();
    issue_cmd(8'h33, 9'd0, e0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL len0_busy: got %0b expected 1", busy); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL len0_done: got %0b expected 1", done); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_busy_after: got %0b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL len0_done_after: got %0b expected 0", done); end
    repeat (4) @(negedge clk);
    #1;
    total++; if (done_cnt != 1) begin bad++; $display("FAIL len0_done_cnt: got %0d expected 1", done_cnt); end
    total++; if (beats.size() != 0) begin bad++; $display("FAIL len0_beats: got %0d expected 0", beats.size()); end
  endtask

  task automatic test_ignore_start();
    int e0;
    clear_mon();
    issue_cmd(8'h50, 9'd4, e0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h90; length = 9'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(30);
    repeat (5) @(negedge clk);
    #1;
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done: got %0d expected 1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy: got %0b expected 0", busy); end
    total++; if (beats.size() != 4) begin bad++; $display("FAIL ign_count: got %0d expected 4", beats.size()); end
    for (int k = 0; k < beats.size() && k < 4; k++) begin
      logic [8:0] exp_b;
      exp_b = {(k == 3), 8'h50 + 8'(k)};
      total++; if (beats[k] !== exp_b) begin bad++; $display("FAIL ign_beat%0d: got %0h expected %0h", k, beats[k], exp_b); end
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    clear_mon();
    issue_cmd(8'h60, 9'd6, e0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (beats.size() >= 2) break;
    end
    total++; if (beats.size() != 2) begin bad++; $display("FAIL rm_pre_beats: got %0d expected 2", beats.size()); end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %0b expected 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %0b expected 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rm_data: got %0h expected 0", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rm_last: got %0b expected 0", out_last); end
    total++; if (ram_addr !== 8'h00) begin bad++; $display("FAIL rm_addr: got %0h expected 0", ram_addr); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rm_done: got %0b expected 0", done); end
    clear_mon();
    @(posedge clk); #1;
    reset = 1'b0;
    issue_cmd(8'h40, 9'd2, e0);
    wait_done(30);
    repeat (4) @(negedge clk);
    #1;
    total++; if (done_cnt != 1) begin bad++; $display("FAIL rm_done_cnt: got %0d expected 1", done_cnt); end
    total++; if (beats.size() != 2) begin bad++; $display("FAIL rm_count: got %0d expected 2", beats.size()); end
    for (int k = 0; k < beats.size() && k < 2; k++) begin
      logic [8:0] exp_b;
      exp_b = {(k == 1), 8'h40 + 8'(k)};
      total++; if (beats[k] !== exp_b) begin bad++; $display("FAIL rm_beat%0d: got %0h expected %0h", k, beats[k], exp_b); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_wrap200();
    test_backpressure();
    test_len0();
    test_ignore_start();
    test_reset_mid();
    total++; if (ovf != 0) begin bad++; $display("FAIL overflow_total: got %0d expected 0", ovf); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
